// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronises the RX line, validates the start bit, samples
// data/parity/stop at mid-bit and holds the byte plus status for a ready/read handshake.
module uart_rx_engine #(
    parameter int BAUD_DEFAULT_CNT = 868,
    parameter int SYNC_STAGES      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic [3:0] baud,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       perr,
    output logic       ferr,
    output logic       ovf
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic logic [18:0] bit_period(input logic [3:0] code);
        case (code)
            4'd0:    return 19'd333333;
            4'd1:    return 19'd83333;
            4'd2:    return 19'd41667;
            4'd3:    return 19'd20833;
            4'd4:    return 19'd10417;
            4'd5:    return 19'd5208;
            4'd6:    return 19'd2604;
            4'd7:    return 19'd1736;
            4'd8:    return 19'd868;
            4'd9:    return 19'd434;
            4'd10:   return 19'd217;
            4'd11:   return 19'd109;
            default: return 19'(BAUD_DEFAULT_CNT);
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_t      state_q, state_d;
    logic [18:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        stop_q, stop_d;
    logic        done_q, done_d;
    logic        cfg_load;
    logic        expired;
    logic [2:0]  last_bit;

    logic [18:0] period_q;
    logic        eight_q, pen_q, ohel_q;

    logic [7:0]  data_mask;
    logic        par_calc;

    // NOTE: the synchroniser resets to 1 (line idle) so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign expired  = (cnt_q == '0);
    assign last_bit = eight_q ? 3'd7 : 3'd6;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
        end
    end

    // Frame format is frozen at start detection; later switch changes wait for the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_q <= '0;
            eight_q  <= 1'b0;
            pen_q    <= 1'b0;
            ohel_q   <= 1'b0;
        end else if (cfg_load) begin
            period_q <= bit_period(baud);
            eight_q  <= eight;
            pen_q    <= pen;
            ohel_q   <= ohel;
        end
    end

    // NOTE: every comb output gets a hold/default value first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == IDLE || expired) ? cnt_q : cnt_q - 19'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        stop_d    = stop_q;
        done_d    = 1'b0;
        cfg_load  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d  = START;
                    cnt_d    = (bit_period(baud) >> 1) - 19'd1;
                    shift_d  = '0;
                    cfg_load = 1'b1;
                end
            end
            START: begin
                if (expired) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                        cnt_d     = period_q - 19'd1;
                    end
                end
            end
            DATA: begin
                if (expired) begin
                    shift_d[bit_idx_q] = rx_s;
                    cnt_d              = period_q - 19'd1;
                    if (bit_idx_q == last_bit) begin
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (expired) begin
                    par_d   = rx_s;
                    state_d = STOP;
                    cnt_d   = period_q - 19'd1;
                end
            end
            STOP: begin
                if (expired) begin
                    stop_d  = rx_s;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_mask = {eight_q, 7'h7F};
    assign par_calc  = ^(shift_q & data_mask);

    // Completion has priority over a coincident read; a lone read clears the status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data <= '0;
            rx_rdy  <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end else if (done_q) begin
            rx_data <= shift_q & data_mask;
            rx_rdy  <= 1'b1;
            perr    <= pen_q & (par_calc ^ par_q ^ ohel_q);
            ferr    <= ~stop_q;
            ovf     <= rx_rdy & ~rx_read;
        end else if (rx_read) begin
            rx_rdy <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            ovf    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: directed frames plus randomized formats
// checked against a bit-level reference of the UART frame rules.
module tb_uart_rx_engine;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [3:0] baud;
    logic       eight;
    logic       pen;
    logic       ohel;
    logic       rx_read;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       perr;
    logic       ferr;
    logic       ovf;

    int total = 0;
    int bad   = 0;
    int lat   = 0;

    always #5 clk = ~clk;

    uart_rx_engine #(
        .BAUD_DEFAULT_CNT(868),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx),
        .baud   (baud),
        .eight  (eight),
        .pen    (pen),
        .ohel   (ohel),
        .rx_read(rx_read),
        .rx_data(rx_data),
        .rx_rdy (rx_rdy),
        .perr   (perr),
        .ferr   (ferr),
        .ovf    (ovf)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int period_of(input logic [3:0] code);
        int table_n [12] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217, 109};
        if (code >= 4'd12) return 868;
        return table_n[code];
    endfunction

    // Parity error rule: total ones over active data bits plus parity bit must match the sense.
    function automatic logic exp_perr(input logic [7:0] d, input bit has_par, input bit par_bit, input bit odd);
        int ones;
        if (!has_par) return 1'b0;
        ones = $countones(d) + int'(par_bit);
        return odd ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    // Edges from the first clock that sees the start edge to the edge that loads rx_rdy:
    // synchroniser, half a bit to mid-start, m further bit periods to mid-stop, one output register.
    function automatic int load_edge(input int n, input int m);
        return SYNC + n / 2 + n * m + 1;
    endfunction

    // Drives one frame starting at a falling clock edge; ends on a falling edge with the line idle.
    task automatic send_frame(input logic [7:0] data, input int nbits, input bit has_par,
                              input bit par_bit, input bit stop_bit, input int n);
        rx = 1'b0;
        repeat (n) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = data[i];
            repeat (n) @(negedge clk);
        end
        if (has_par) begin
            rx = par_bit;
            repeat (n) @(negedge clk);
        end
        if (stop_bit) begin
            rx = 1'b1;
            repeat (n) @(negedge clk);
        end else begin
            // Low stop is cut short after its sample point so the line is plainly idle afterwards.
            rx = 1'b0;
            repeat (n / 2 + 8) @(negedge clk);
            rx = 1'b1;
            repeat (n) @(negedge clk);
        end
    endtask

    task automatic pulse_read();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] d_exp;
        bit         p_bit;
        int         n;
        int         nb;

        rx      = 1'b1;
        reset   = 1'b0;
        baud    = 4'd8;
        eight   = 1'b1;
        pen     = 1'b0;
        ohel    = 1'b0;
        rx_read = 1'b0;

        #1;
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_flags", {28'h0, rx_rdy, perr, ferr, ovf}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 8N1 at 868 clocks/bit, with exact completion latency
        fork
            send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 868);
            begin
                @(posedge clk);
                while (rx_rdy !== 1'b1 && lat < 20000) begin
                    @(posedge clk);
                    lat++;
                    #1;
                end
            end
        join
        check("a5_latency", 32'(lat), 32'(load_edge(868, 9)));
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_flags", {28'h0, rx_rdy, perr, ferr, ovf}, 32'b1000);
        pulse_read();
        check("a5_read_rdy", 32'(rx_rdy), 32'h0);
        check("a5_read_data_held", 32'(rx_data), 32'hA5);

        // 7E1: correct parity, then wrong parity
        eight = 1'b0;
        pen   = 1'b1;
        ohel  = 1'b0;
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 868);
        check("7e1_good_data", 32'(rx_data), 32'h41);
        check("7e1_good_perr", 32'(perr), 32'(exp_perr(8'h41, 1'b1, 1'b0, 1'b0)));
        pulse_read();
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 868);
        check("7e1_bad_rdy", 32'(rx_rdy), 32'h1);
        check("7e1_bad_perr", 32'(perr), 32'(exp_perr(8'h41, 1'b1, 1'b1, 1'b0)));
        pulse_read();

        // 8O1 at 109 clocks/bit: good parity, then framing error
        baud  = 4'd11;
        eight = 1'b1;
        ohel  = 1'b1;
        send_frame(8'h00, 8, 1'b1, 1'b1, 1'b1, 109);
        check("8o1_perr", 32'(perr), 32'h0);
        check("8o1_ferr", 32'(ferr), 32'h0);
        pulse_read();
        send_frame(8'h00, 8, 1'b1, 1'b1, 1'b0, 109);
        check("ferr_flag", 32'(ferr), 32'h1);
        check("ferr_rdy", 32'(rx_rdy), 32'h1);
        check("ferr_data", 32'(rx_data), 32'h00);
        pulse_read();
        check("ferr_cleared", {28'h0, rx_rdy, perr, ferr, ovf}, 32'h0);

        // Glitch shorter than half a bit at baud 8
        baud = 4'd8;
        pen  = 1'b0;
        ohel = 1'b0;
        rx   = 1'b0;
        repeat (300) @(negedge clk);
        rx = 1'b1;
        repeat (600) @(negedge clk);
        check("glitch_flags", {28'h0, rx_rdy, perr, ferr, ovf}, 32'h0);

        // Randomized formats against the frame reference
        for (int i = 0; i < 5; i++) begin
            baud  = (i == 4) ? 4'd14 : 4'($urandom_range(10, 11));
            eight = 1'($urandom);
            pen   = 1'($urandom);
            ohel  = 1'($urandom);
            d     = 8'($urandom);
            p_bit = 1'($urandom);
            n     = period_of(baud);
            nb    = eight ? 8 : 7;
            d_exp = eight ? d : (d & 8'h7F);
            send_frame(d, nb, pen, p_bit, 1'b1, n);
            check($sformatf("rand%0d_data", i), 32'(rx_data), 32'(d_exp));
            check($sformatf("rand%0d_perr", i), 32'(perr), 32'(exp_perr(d_exp, pen, p_bit, ohel)));
            check($sformatf("rand%0d_rdy_ferr_ovf", i), {29'h0, rx_rdy, ferr, ovf}, 32'b100);
            pulse_read();
        end

        // Overrun, then a read landing on the completion cycle
        baud  = 4'd8;
        eight = 1'b1;
        pen   = 1'b0;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 868);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 868);
        check("ovr_data", 32'(rx_data), 32'h33);
        check("ovr_flags", {28'h0, rx_rdy, perr, ferr, ovf}, 32'b1001);
        fork
            send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b1, 868);
            begin
                repeat (load_edge(868, 9)) @(posedge clk);
                @(negedge clk);
                rx_read = 1'b1;
                @(negedge clk);
                rx_read = 1'b0;
            end
        join
        check("rdwin_data", 32'(rx_data), 32'hF0);
        check("rdwin_flags", {28'h0, rx_rdy, perr, ferr, ovf}, 32'b1000);

        // Asynchronous reset in the middle of the data bits
        baud = 4'd11;
        fork
            send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 109);
            begin
                repeat (109 * 4) @(negedge clk);
                #2;
                reset = 1'b0;
                #1;
                check("midrst_data", 32'(rx_data), 32'h0);
                check("midrst_flags", {28'h0, rx_rdy, perr, ferr, ovf}, 32'h0);
            end
        join
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 109);
        check("post_rst_data", 32'(rx_data), 32'hC3);
        check("post_rst_flags", {28'h0, rx_rdy, perr, ferr, ovf}, 32'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Serial receive engine of the UART SoC; sits directly downstream of the board input buffer stage.
- Consumes the buffered RX line plus the buffered BAUD/EIGHT/PEN/OHEL switch settings.
- Synchronises RX, detects and validates the start bit, and samples data/parity/stop at mid-bit.
- Presents the received byte and status flags to the Tramelblaze read port with a ready/read handshake.

Parameters:
- BAUD_DEFAULT_CNT, 868, bit period in clocks used for BAUD codes 12-15 (115200 baud at 100 MHz).
- SYNC_STAGES, 2, number of RX synchroniser flops (minimum 2).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  buffered serial line; idles high.
- baud  input  4  baud select code.
- eight  input  1  1 = 8 data bits; 0 = 7 data bits.
- pen  input  1  1 = parity bit present.
- ohel  input  1  parity sense: 1 = odd, 0 = even.
- rx_read  input  1  single-cycle pulse from the processor; consumes the current byte and flags.
- rx_data  output  8  received byte, LSB first on the wire; bit 7 = 0 in 7-bit mode.
- rx_rdy  output  1  byte available, held high until read.
- perr  output  1  parity error on the held byte.
- ferr  output  1  framing error (stop bit sampled 0).
- ovf  output  1  overrun: a new frame completed while rx_rdy = 1.

Behaviour:
- Reset is asynchronous and active-low. On assertion: state = IDLE; counters = 0; synchroniser flops = 1; rx_data = 0; rx_rdy, perr, ferr, ovf = 0.
- Bit period N (clocks) by baud code: 0 = 333333, 1 = 83333, 2 = 41667, 3 = 20833, 4 = 10417, 5 = 5208, 6 = 2604, 7 = 1736, 8 = 868, 9 = 434, 10 = 217, 11 = 109, 12-15 = BAUD_DEFAULT_CNT.
- baud/eight/pen/ohel are latched on entry to START and held for the whole frame.
- rx_s is the synchronised rx (SYNC_STAGES flops). The bit counter holds 0..N-1 and needs 19 bits.
- State IDLE: when rx_s = 0, go to START and load the counter for N/2 (integer divide).
- State START: at the half-bit point, if rx_s = 1 this is a false start; return to IDLE with no flag or output change. If rx_s = 0, go to DATA with bit index 0; counter = N.
- State DATA: at each counter expiry, shift rx_s into the data shift register, LSB first. After 7 or 8 bits (per eight), go to PARITY if pen = 1, otherwise to STOP.
- State PARITY: at expiry, sample the parity bit. Error when the XOR of the data bits XOR the parity bit ≠ ohel (odd: total ones must be odd; even: total ones must be even). Parity is computed only over the active data bits.
- State STOP: at expiry, sample the stop bit and complete the frame on that same edge. Frame completion registers on the next clock edge:
  - rx_data ← shift register, with bit 7 forced to 0 in 7-bit mode.
  - rx_rdy ← 1.
  - perr ← computed parity error, or 0 if pen = 0.
  - ferr ← (stop sample = 0).
  - ovf ← (rx_rdy = 1 and rx_read = 0).
  - Return to IDLE. A new start can be detected from the next clock; no wait for the end of the stop bit.
- Framing error: the frame is still delivered (rx_rdy = 1) with ferr = 1. No break handling.
- rx_read with no completion in the same cycle: rx_rdy, perr, ferr, ovf ← 0 on the next edge. rx_data is held.
- rx_read in the same cycle as a completion: the completion wins. The new byte and flags load, rx_rdy stays 1, and ovf = 0.
- rx_read while rx_rdy = 0: no effect.
- baud changes mid-frame: no effect until the next START.
- Latency: rx_rdy rises 1 clock after the mid-stop-bit sample edge.

Test Plan:
- 8N1, baud = 8: send 0xA5 (868 clk/bit) → rx_data = 0xA5, rx_rdy = 1 about 9.5 bit times after the start edge; perr = ferr = ovf = 0. rx_read pulse → rx_rdy = 0 on the next clock, rx_data still 0xA5.
- 7 data bits, even parity (eight = 0, pen = 1, ohel = 0), baud = 8: send 0x41 with parity = 0 → rx_data = 0x41, perr = 0. Repeat with parity = 1 → perr = 1, rx_rdy = 1.
- 8O1, baud = 11 (109 clk/bit): send 0x00 with parity = 1 → perr = 0. Then send 0x00 with the stop bit driven 0 → ferr = 1, rx_data = 0x00.
- Glitch: rx low for 300 clocks at baud = 8 (N/2 = 434) → state back to IDLE, rx_rdy stays 0, no flags set.
- Overrun: two 0x55/0x33 frames back-to-back with no rx_read → rx_data = 0x33, ovf = 1. Third frame with rx_read pulsed on the exact completion cycle → rx_rdy = 1, ovf = 0.
- Reset low mid-DATA of a frame → all outputs 0 immediately (asynchronous). After release, the next full frame 0xC3 is received correctly.
